jtag_host_shifter: RTL

//  JTAG host: drives TCK/TMS/TDI and samples TDO of an XC9500-class target on the 8-way

---
 rtl/jtag_host_shifter_pkg.sv | 43 ++++
 rtl/jtag_host_shifter_tck_gen.sv | 39 +++
 rtl/jtag_host_shifter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/jtag_host_shifter_pkg.sv
// rtl/jtag_host_shifter_pkg.sv - op codes, FSM states and TMS preambles for the JTAG host
package jtag_pkg;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IDLE  = 2'b01;
  localparam logic [1:0] OP_IR    = 2'b10;
  localparam logic [1:0] OP_DR    = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Preamble TMS patterns, bit0 driven on the first TCK.
  localparam logic [7:0] PRE_TMS_RESET = 8'b0001_1111;
  localparam logic [7:0] PRE_TMS_IR    = 8'b0000_0011;
  localparam logic [7:0] PRE_TMS_DR    = 8'b0000_0001;

  localparam logic [2:0] PRE_LEN_RESET = 3'd6;
  localparam logic [2:0] PRE_LEN_IR    = 3'd4;
  localparam logic [2:0] PRE_LEN_DR    = 3'd3;

  function automatic logic [7:0] pre_tms(input logic [1:0] op);
    case (op)
      OP_RESET: pre_tms = PRE_TMS_RESET;
      OP_IR:    pre_tms = PRE_TMS_IR;
      OP_DR:    pre_tms = PRE_TMS_DR;
      default:  pre_tms = 8'h00;
    endcase
  endfunction

  // Ticks remaining after the first preamble tick; IDLE takes its count from cmd_len.
  function automatic logic [2:0] pre_last(input logic [1:0] op);
    case (op)
      OP_RESET: pre_last = PRE_LEN_RESET - 3'd1;
      OP_IR:    pre_last = PRE_LEN_IR - 3'd1;
      OP_DR:    pre_last = PRE_LEN_DR - 3'd1;
      default:  pre_last = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_host_shifter_tck_gen.sv
// rtl/jtag_host_shifter_tck_gen.sv - TCK divider with edge strobes
// Strobes flag the clk edge that is about to drive tck high or low.
module jtag_tck_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last     = (cnt == CMAX);
  assign rise_stb = en & last & ~tck;
  assign fall_stb = en & last & tck;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (last) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_host_shifter.sv
// rtl/jtag_host_shifter.sv - JTAG host: RESET/IDLE/IR/DR commands walked from Run-Test/Idle
// tms/tdi for the next tick are loaded on the edge that drives tck low.
module jtag_host_shifter
  import jtag_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6,
  parameter int DIV    = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam logic [LEN_W-1:0] MAXL = LEN_W'(DATA_W - 1);

  logic [2:0]        state;
  logic              scan_q;
  logic [LEN_W-1:0]  last_q;
  logic [LEN_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  pre_left;
  logic [7:0]        pre_sr;
  logic [7:0]        pat;
  logic              post_sec;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] cap;
  logic              en;
  logic              fall_stb;
  logic              rise_stb;
  logic              accept;

  assign cmd_ready = (state == ST_IDLE) | (state == ST_DONE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state == ST_DONE) & scan_q;
  assign accept    = cmd_valid & cmd_ready;
  assign en        = (state == ST_PRE) | (state == ST_SHIFT) | (state == ST_POST);
  assign pat       = pre_tms(cmd_op);

  jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
    .clk      (clk),
    .resetb   (resetb),
    .en       (en),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= ST_IDLE;
      scan_q   <= 1'b0;
      last_q   <= '0;
      bit_cnt  <= '0;
      pre_left <= '0;
      pre_sr   <= '0;
      post_sec <= 1'b0;
      data_sr  <= '0;
      cap      <= '0;
      rsp_data <= '0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
    end else if (accept) begin
      state    <= ST_PRE;
      scan_q   <= cmd_op[1];
      last_q   <= (cmd_len > MAXL) ? MAXL : cmd_len;
      bit_cnt  <= '0;
      post_sec <= 1'b0;
      data_sr  <= cmd_data;
      cap      <= '0;
      tms      <= pat[0];
      tdi      <= 1'b0;
      pre_sr   <= {1'b0, pat[7:1]};
      pre_left <= (cmd_op == OP_IDLE) ? cmd_len : LEN_W'(pre_last(cmd_op));
    end else begin
      case (state)
        ST_DONE: state <= ST_IDLE;
        ST_PRE: begin
          if (fall_stb) begin
            if (pre_left != '0) begin
              tms      <= pre_sr[0];
              pre_sr   <= {1'b0, pre_sr[7:1]};
              pre_left <= pre_left - LEN_W'(1);
            end else if (scan_q) begin
              state <= ST_SHIFT;
              tms   <= (last_q == '0);
              tdi   <= data_sr[0];
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (rise_stb) begin
            cap <= cap | (DATA_W'(tdo) << bit_cnt);
          end
          if (fall_stb) begin
            if (bit_cnt == last_q) begin
              state <= ST_POST;
              tms   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + LEN_W'(1);
              data_sr <= {1'b0, data_sr[DATA_W-1:1]};
              tdi     <= data_sr[1];
              tms     <= ((bit_cnt + LEN_W'(1)) == last_q);
            end
          end
        end
        ST_POST: begin
          // Update-xR tick first, then the Run-Test/Idle tick.
          if (fall_stb) begin
            if (!post_sec) begin
              tms      <= 1'b0;
              post_sec <= 1'b1;
            end else begin
              state    <= ST_DONE;
              tdi      <= 1'b0;
              rsp_data <= cap;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
